// File: rtl/uart_tx.sv
// UART transmitter: one 8N1 frame per accepted byte, LSB first, registered outputs.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop (8E1).
module uart_tx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int UART_BPS = 115200,
  parameter int DATA_DLY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_tx_en,
  input  logic [7:0] uart_tx_data,
  output logic       uart_tx_busy,
  output logic       uart_tx_done,
  output logic       uart_txd
);

  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int CW      = $clog2(BPS_CNT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BPS_CNT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          pend_q, pend_d;
  logic          busy_d, done_d, txd_d;

  // Handshake: uart_tx_en is taken only in an IDLE cycle (busy low); busy is
  // registered from the next state, so it is high from the very next cycle.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    data_d  = data_q;
    pend_d  = 1'b0;
    if (pend_q) data_d = uart_tx_data;
    if (state_q == S_IDLE) begin
      if (uart_tx_en) begin
        state_d = S_START;
        baud_d  = '0;
        bit_d   = '0;
        if (DATA_DLY == 0) data_d = uart_tx_data;
        else               pend_d = 1'b1;
      end
    end else if (baud_q != BAUD_LAST) begin
      baud_d = baud_q + 1'b1;
    end else begin
      baud_d = '0;
      case (state_q)
        S_START: state_d = S_DATA;
        S_DATA: begin
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: state_d = S_STOP;
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are computed from the next state so the pins come straight off flops.
  always_comb begin
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_STOP) && (baud_d == BAUD_LAST);
    case (state_d)
      S_START:   txd_d = 1'b0;
      S_DATA:    txd_d = data_d[bit_d];
`ifdef UART_TX_PARITY_EN
      S_PARITY:  txd_d = ^data_d;
`endif
      default:   txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      baud_q       <= '0;
      bit_q        <= '0;
      data_q       <= '0;
      pend_q       <= 1'b0;
      uart_tx_busy <= 1'b0;
      uart_tx_done <= 1'b0;
      uart_txd     <= 1'b1;
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      data_q       <= data_d;
      pend_q       <= pend_d;
      uart_tx_busy <= busy_d;
      uart_tx_done <= done_d;
      uart_txd     <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: DATA_DLY=1 and DATA_DLY=0 instances share one stimulus stream,
// checked cycle by cycle against a frame-timing model plus a serial receiver.
module tb_uart_tx;

  localparam int B = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_en = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       busy1, done1, txd1;
  logic       busy0, done0, txd0;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  // model state: current frame accepted in cycle ft, bytes as each instance samples them
  bit         fv = 1'b0;
  int         ft = 0;
  logic [7:0] d0 = 8'h00;
  logic [7:0] d1 = 8'h00;
  bit         samp_pend = 1'b0;
  logic [7:0] exp_q0[$];

  always #5 clk = ~clk;

  uart_tx #(.CLK_FREQ(1000), .UART_BPS(100), .DATA_DLY(1)) dut1 (
    .clk(clk), .rst(rst), .uart_tx_en(tx_en), .uart_tx_data(tx_data),
    .uart_tx_busy(busy1), .uart_tx_done(done1), .uart_txd(txd1)
  );

  uart_tx #(.CLK_FREQ(1000), .UART_BPS(100), .DATA_DLY(0)) dut0 (
    .clk(clk), .rst(rst), .uart_tx_en(tx_en), .uart_tx_data(tx_data),
    .uart_tx_busy(busy0), .uart_tx_done(done0), .uart_txd(txd0)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic in_frame(input int c);
    return fv && (c >= ft + 1) && (c <= ft + NBITS * B);
  endfunction

  // expected line level: bit k of the frame occupies cycles ft+1+k*B .. ft+(k+1)*B
  function automatic logic exp_line(input int c, input logic [7:0] d);
    int k;
    if (!in_frame(c)) return 1'b1;
    k = (c - ft - 1) / B;
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (NBITS == 11 && k == 9) return ^d;
    return 1'b1;
  endfunction

  // one clock cycle: check outputs for this cycle, then apply this cycle's inputs
  task automatic step(input logic en, input logic [7:0] d, input logic r);
    @(negedge clk);
    cyc++;
    if (cyc > 1) begin
      chk("txd1", {7'd0, txd1}, {7'd0, exp_line(cyc, d1)});
      chk("txd0", {7'd0, txd0}, {7'd0, exp_line(cyc, d0)});
      chk("busy1", {7'd0, busy1}, {7'd0, in_frame(cyc)});
      chk("busy0", {7'd0, busy0}, {7'd0, in_frame(cyc)});
      chk("done1", {7'd0, done1}, {7'd0, fv && (cyc == ft + NBITS * B)});
      chk("done0", {7'd0, done0}, {7'd0, fv && (cyc == ft + NBITS * B)});
    end
    if (samp_pend) begin
      d1 = d;
      samp_pend = 1'b0;
    end
    rst     = r;
    tx_en   = en;
    tx_data = d;
    if (r) begin
      fv = 1'b0;
      samp_pend = 1'b0;
      exp_q0.delete();
    end else if (en && !in_frame(cyc)) begin
      fv = 1'b1;
      ft = cyc;
      d0 = d;
      samp_pend = 1'b1;
      exp_q0.push_back(d);
    end
  endtask

  // serial receiver on the DATA_DLY=0 line, sampling mid-bit
  bit         rx_act = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte = 8'h00;

  always @(negedge clk) begin
    #1;
    if (rst) begin
      rx_act = 1'b0;
    end else if (!rx_act) begin
      if (txd0 === 1'b0) begin
        rx_act  = 1'b1;
        rx_cnt  = 0;
        rx_byte = 8'h00;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % B == B / 2) begin
        if (rx_cnt / B >= 1 && rx_cnt / B <= 8) begin
          rx_byte[rx_cnt/B-1] = txd0;
`ifdef UART_TX_PARITY_EN
        end else if (rx_cnt / B == 9) begin
          chk("rx_parity", {7'd0, txd0}, {7'd0, ^rx_byte});
`endif
        end else if (rx_cnt / B == NBITS - 1) begin
          chk("rx_stop", {7'd0, txd0}, 8'd1);
          if (exp_q0.size() == 0) chk("rx_extra", 8'd1, 8'd0);
          else chk("rx_byte", rx_byte, exp_q0.pop_front());
          rx_act = 1'b0;
        end
      end
    end
  end

  initial begin
    // reset held, then long idle with no request
    repeat (3) step(1'b0, 8'h00, 1'b1);
    repeat (200) step(1'b0, 8'h00, 1'b0);

    // single pulse, data presented one cycle after en
    step(1'b1, 8'h5A, 1'b0);
    step(1'b0, 8'hA5, 1'b0);
    repeat (120) step(1'b0, 8'h00, 1'b0);

    // DATA_DLY=0 sees 8'h01, DATA_DLY=1 sees 8'hFF
    step(1'b1, 8'h01, 1'b0);
    repeat (120) step(1'b0, 8'hFF, 1'b0);

    // en held high: back-to-back frames, no mid-frame acceptance
    repeat (300) step(1'b1, 8'h3C, 1'b0);
    repeat (120) step(1'b0, 8'h00, 1'b0);

    // parity reference bytes
    step(1'b1, 8'h07, 1'b0);
    repeat (120) step(1'b0, 8'h07, 1'b0);
    step(1'b1, 8'h03, 1'b0);
    repeat (120) step(1'b0, 8'h03, 1'b0);

    // reset in the middle of the data bits, then a fresh frame
    step(1'b1, 8'hC3, 1'b0);
    repeat (44) step(1'b0, 8'hC3, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    repeat (20) step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h96, 1'b0);
    repeat (120) step(1'b0, 8'h96, 1'b0);

    // random requests and data churn, including requests while busy
    repeat (2500) step($urandom_range(0, 7) == 0, 8'($urandom), 1'b0);
    repeat (150) step(1'b0, 8'($urandom), 1'b0);

    chk("rx_pending", 8'(exp_q0.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
